// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer with valid/ready operand and result handshakes
//
// Purpose:
//   Adds two WIDTH-bit operands one bit per clock, LSB first, through a
//   registered full-adder stage. Operands arrive over an in_valid/in_ready
//   handshake. The sum and carry-out leave over an out_valid/out_ready
//   handshake. The result appears exactly WIDTH edges after acceptance.
//
// Optional feature:
//   SERIAL_SUB_EN - when defined, adds input op_sub. With op_sub=1 the block
//   computes A-B in two's complement, and carry_out is the not-borrow flag.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   operand pair on op_a/op_b is valid
//   in_ready   out  operands can be accepted (IDLE only)
//   op_a       in   WIDTH-bit addend A
//   op_b       in   WIDTH-bit addend B
//   op_sub     in   (SERIAL_SUB_EN only) 1 = subtract, sampled on acceptance
//   out_valid  out  sum/carry_out valid (DONE only)
//   out_ready  in   consumer accepts the result
//   sum        out  registered WIDTH-bit result
//   carry_out  out  registered carry out of bit WIDTH-1
//   busy       out  high in RUN and DONE

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  // Holds the WIDTH-1 most recent partial-sum bits; the final bit comes
  // straight from the adder on the DONE-entry edge.
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_init;

  // Operand load selection: subtraction is A + ~B + 1.
`ifdef SERIAL_SUB_EN
  assign w_b_load = op_sub ? ~op_b : op_b;
  assign w_c_init = op_sub;
`else
  assign w_b_load = op_b;
  assign w_c_init = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

  // One full-adder bit per clock.
  assign w_s = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));

  // New bit enters at the MSB, older bits move toward the LSB.
  assign w_shift = {w_s, r_res};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode; outputs depend on state only.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Serial datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= op_a;
      r_b   <= w_b_load;
      r_c   <= w_c_init;
      r_cnt <= '0;
      r_res <= '0;
    end else if (r_state == RUN) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_c   <= w_c;
      r_cnt <= r_cnt + 1'b1;
      r_res <= w_shift[WIDTH-1:1];
      // Only the completed result is published; partial sums stay internal.
      if (w_last) begin
        r_sum  <= w_shift;
        r_cout <= w_c;
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SERIAL_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a result of a+b (or a+~b+1) becomes visible exactly
  // W edges after acceptance and stays until an edge with out_ready=1.
  int           cyc;
  int           m_acc_cyc;
  bit           m_pending;
  bit           m_done;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic [W:0]   m_result;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc       = 0;
      m_pending = 0;
      m_done    = 0;
      m_sum     = '0;
      m_cout    = 1'b0;
    end else begin
      cyc++;
      if (m_done) begin
        if (out_ready) m_done = 0;
      end else if (m_pending) begin
        if (cyc - m_acc_cyc == W) begin
          m_pending = 0;
          m_done    = 1;
          {m_cout, m_sum} = m_result;
        end
      end else if (in_valid) begin
        m_pending = 1;
        m_acc_cyc = cyc;
        m_result  = {1'b0, op_a} + {1'b0, op_b};
`ifdef SERIAL_SUB_EN
        if (op_sub) m_result = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
`endif
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check("in_ready",  32'(in_ready),  32'(!m_pending && !m_done));
    check("out_valid", 32'(out_valid), 32'(m_done));
    check("busy",      32'(busy),      32'(m_pending || m_done));
    check("sum",       32'(sum),       32'(m_sum));
    check("carry_out", 32'(carry_out), 32'(m_cout));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid after the acceptance edge; returns edges counted.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: out_valid never rose within 40 cycles");
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [W-1:0] exp_sum, input logic exp_cout);
    int n;
    check({name, "_ready"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom;
    wait_done(n);
    check({name, "_latency"}, 32'(n), 32'd8);
    check({name, "_sum"},     32'(sum), 32'(exp_sum));
    check({name, "_cout"},    32'(carry_out), 32'(exp_cout));
    out_ready = 1'b1;
    step();
    check({name, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); op_a = $urandom; op_b = $urandom; out_ready = 1'($urandom);
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(sum), 32'h00);
      check("rst_cout", 32'(carry_out), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    step();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // 2-3: basic add and wrap-around
    do_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

    // 4: backpressure with a pending operand held in DONE
    out_ready = 1'b0;
    op_a = 8'h12; op_b = 8'h34; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(n);
    check("bp_latency", 32'(n), 32'd8);
    op_a = 8'h77; op_b = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_sum", 32'(sum), 32'h46);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_to_idle", 32'(in_ready), 32'd1);
    step();
    check("bp_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_done(n);
    check("bp_77_latency", 32'(n), 32'd8);
    check("bp_77_sum", 32'(sum), 32'h77);
    step();

    // 5: reset mid-RUN
    op_a = 8'h0F; op_b = 8'h01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'h00);
    step();
    rst = 1'b1;
    step();
    do_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

`ifdef SERIAL_SUB_EN
    // 6: subtraction
    do_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    do_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);
    do_op("add_sub0",  8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer built around a registered sum/carry stage (one full-adder bit per clock). It accepts a pair of WIDTH-bit operands over a valid/ready handshake and steps them LSB-first through the registered stage. It then presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between an operand producer and a result consumer and trades area for WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; localparam derived from WIDTH, not overridable.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
in_valid  input  1  operand pair on op_a/op_b is valid.
in_ready  output  1  block can accept operands; high only in IDLE.
op_a  input  WIDTH  addend A.
op_b  input  WIDTH  addend B.
out_valid  output  1  sum/carry_out are valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered result.
carry_out  output  1  registered carry out of bit WIDTH-1.
busy  output  1  high in RUN and DONE.

Behaviour:
- Reset values while rst=0: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0. Shift registers, carry register and counter are all 0.
- FSM states: IDLE, RUN, DONE. Outputs in_ready, out_valid and busy are decoded from state only; there is no combinational path from input to output.
- IDLE: on an edge with in_valid=1, the operands are accepted.
  - Latch op_a and op_b into shift registers.
  - Clear the carry register to 0 and the counter to 0.
  - Go to RUN.
  - With in_valid=0, stay in IDLE. sum and carry_out hold their last values.
- RUN: each edge processes one bit.
  - s = a[0]^b[0]^c
  - c <= (a[0]&b[0]) | (c&(a[0]^b[0]))
  - Shift a and b right by 1. Shift s into the MSB of the result shift register, which shifts right.
  - Increment the counter.
  - On the edge where the counter reaches WIDTH-1, i.e. the WIDTH-th bit is processed: load the result shift register into sum, load c into carry_out, and go to DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the acceptance edge.
- sum and carry_out change only on the DONE-entry edge, and otherwise hold. Intermediate partial sums never appear on the sum port.
- DONE: out_valid=1. Hold sum and carry_out stable until an edge with out_ready=1, then go to IDLE.
- Backpressure: out_ready=0 holds DONE indefinitely.
- in_valid in RUN or DONE: ignored, because in_ready=0. Operands are not captured, and the producer must hold them.
- Simultaneous out_ready=1 and a pending in_valid in DONE: the next acceptance happens no earlier than the following edge, in IDLE.
- Minimum issue interval: WIDTH+2 cycles.
- op_a/op_b changing after acceptance: no effect on the operation in progress.
- Arithmetic: unsigned modulo 2^WIDTH; carry_out is bit WIDTH of the true sum.
- Reset mid-operation (rst=0 in RUN or DONE): immediate abort to the reset values. No result is produced and the partial operation is discarded.

Optional Feature:
Macro SERIAL_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), sampled only on the acceptance edge.
  - op_sub=1 latches ~op_b and initialises the carry register to 1, giving A-B in two's complement.
  - carry_out is then the not-borrow flag: 1 when A>=B unsigned.
  - op_sub=0 gives addition exactly as above.
- Undefined:
  - op_sub port is absent and the block always adds.
  - The carry register always initialises to 0.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with random inputs -> in_ready=1, out_valid=0, busy=0, sum=8'h00, carry_out=0. Release rst -> still IDLE, in_ready=1.
2. Basic add, WIDTH=8: op_a=8'h05, op_b=8'h03, in_valid pulse -> out_valid rises exactly 8 edges after acceptance with sum=8'h08, carry_out=0. Hold out_ready=1 -> in_ready=1 on the next cycle.
3. Wrap-around: op_a=8'hFF, op_b=8'h01 -> sum=8'h00, carry_out=1. Then op_a=8'hFF, op_b=8'hFF -> sum=8'hFE, carry_out=1.
4. Backpressure: complete 8'h12+8'h34 with out_ready=0 for 5 cycles and in_valid=1 with op_a=8'h77 held throughout -> sum=8'h46 stable, out_valid=1, in_ready=0, no capture. After out_ready=1, 8'h77 is accepted in IDLE on the following edge.
5. Reset mid-RUN: pull rst=0 after 3 RUN edges of 8'h0F+8'h01 -> outputs go to reset values immediately. After release, 8'hA5+8'h5A -> sum=8'hFF, carry_out=0.
6. SERIAL_SUB_EN defined:
   - 8'h10-8'h01 (op_sub=1) -> sum=8'h0F, carry_out=1.
   - 8'h00-8'h01 -> sum=8'hFF, carry_out=0.
   - op_sub=0 with 8'h05+8'h03 -> sum=8'h08.
